elevator_scheduler: RTL



---
 rtl/elevator_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN sequencer for a four-floor car.
// Latches one-hot floor requests into a pending set, drives the motor/door
// commands, tracks the car position and reports the floor being served.
module elevator_scheduler #(
    parameter int TRAVEL_CYCLES = 50000000,
    parameter int DOOR_CYCLES   = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_onehot,
    output logic [3:0] current_floor,
    output logic [3:0] pending,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [3:0] ctrl_seq,
    output logic       busy
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_floor;
    logic [3:0]    r_pending;
    logic          r_dir_up;
    logic [CW-1:0] r_travel_cnt;
    logic [CW-1:0] r_door_cnt;

    logic [3:0]    w_floor_nxt;
    logic          w_dir_up_nxt;
    logic [3:0]    w_clear;
    logic [3:0]    w_req_eff;
    logic [3:0]    w_floor_sh;
    logic [3:0]    w_above;
    logic [3:0]    w_below;
    logic [3:0]    w_above_lo;
    logic [3:0]    w_below_hi;
    logic [3:0]    w_floor_up;
    logic [3:0]    w_floor_dn;
    logic          w_moving;
    logic          w_travel_done;
    logic          w_door_done;

    // Pending requests split around the car; the floor is one-hot, so
    // (floor << 1) - 1 masks the car floor and everything below it.
    always_comb begin
        w_floor_sh    = r_floor << 1;
        w_above       = r_pending & ~(w_floor_sh - 4'd1);
        w_below       = r_pending & (r_floor - 4'd1);
        w_above_lo    = w_above & (~w_above + 4'd1);
        w_floor_up    = {r_floor[2:0], 1'b0};
        w_floor_dn    = {1'b0, r_floor[3:1]};
        w_moving      = (r_state == S_MOVE_UP) || (r_state == S_MOVE_DOWN);
        w_travel_done = w_moving && (r_travel_cnt == TRAVEL_LAST);
        w_door_done   = (r_state == S_DOOR_OPEN) && (r_door_cnt == DOOR_LAST);
        // The door is already open at the car floor, so that request is dropped.
        w_req_eff     = req_onehot & ~((r_state == S_DOOR_OPEN) ? r_floor : 4'h0);
    end

    // Highest pending floor below the car (next stop when heading down).
    always_comb begin
        w_below_hi = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (w_below[i]) begin
                w_below_hi    = 4'h0;
                w_below_hi[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: SCAN decision in IDLE, arrival checks while moving.
    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_dir_up_nxt = r_dir_up;
        w_clear      = 4'h0;
        case (r_state)
            S_IDLE: begin
                if ((r_pending & r_floor) != 4'h0) begin
                    w_state_nxt = S_DOOR_OPEN;
                    w_clear     = r_floor;
                end else if ((w_above != 4'h0) && (r_dir_up || (w_below == 4'h0))) begin
                    w_state_nxt  = S_MOVE_UP;
                    w_dir_up_nxt = 1'b1;
                end else if (w_below != 4'h0) begin
                    w_state_nxt  = S_MOVE_DOWN;
                    w_dir_up_nxt = 1'b0;
                end
            end
            S_MOVE_UP: begin
                if (w_travel_done) begin
                    w_floor_nxt = w_floor_up;
                    if ((r_pending & w_floor_up) != 4'h0) begin
                        w_state_nxt = S_DOOR_OPEN;
                        w_clear     = w_floor_up;
                    end
                end
            end
            S_MOVE_DOWN: begin
                if (w_travel_done) begin
                    w_floor_nxt = w_floor_dn;
                    if ((r_pending & w_floor_dn) != 4'h0) begin
                        w_state_nxt = S_DOOR_OPEN;
                        w_clear     = w_floor_dn;
                    end
                end
            end
            S_DOOR_OPEN: begin
                if (w_door_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Position, direction and pending set; clear beats a same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_floor   <= 4'h1;
            r_dir_up  <= 1'b1;
            r_pending <= 4'h0;
        end else begin
            r_floor   <= w_floor_nxt;
            r_dir_up  <= w_dir_up_nxt;
            r_pending <= (r_pending | w_req_eff) & ~w_clear;
        end
    end

    // Segment and door timers, each held at zero outside its own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_travel_cnt <= '0;
            r_door_cnt   <= '0;
        end else begin
            r_travel_cnt <= (w_moving && !w_travel_done) ? r_travel_cnt + 1'b1 : '0;
            r_door_cnt   <= ((r_state == S_DOOR_OPEN) && !w_door_done) ? r_door_cnt + 1'b1 : '0;
        end
    end

    // Output decode from the registered state, position and pending set.
    always_comb begin
        motor_up      = (r_state == S_MOVE_UP);
        motor_down    = (r_state == S_MOVE_DOWN);
        door_open     = (r_state == S_DOOR_OPEN);
        current_floor = r_floor;
        pending       = r_pending;
        busy          = (r_state != S_IDLE) || (r_pending != 4'h0);
        case (r_state)
            S_MOVE_UP:   ctrl_seq = w_above_lo;
            S_MOVE_DOWN: ctrl_seq = w_below_hi;
            S_DOOR_OPEN: ctrl_seq = r_floor;
            default:     ctrl_seq = 4'h0;
        endcase
    end

endmodule
